// File: rtl/cms_trace_stream_receiver.sv
// Trace stream receiver: buffers {tlast, instr, pc} beats in a first-word-fall-through FIFO,
// counts beats and frames, and optionally checks frame length (macro CMS_RX_TLAST_CHECK_EN).
module cms_trace_stream_receiver #(
    parameter int XLEN           = 64,
    parameter int AXI_DATA_WIDTH = 96,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      S_AXIS_tvalid,
    output logic                      S_AXIS_tready,
    input  logic [AXI_DATA_WIDTH-1:0] S_AXIS_tdata,
    input  logic                      S_AXIS_tlast,
    input  logic [31:0]               tlast_interval,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [XLEN-1:0]           out_pc,
    output logic [31:0]               out_instr,
    output logic                      out_last,
    output logic [31:0]               beat_count,
    output logic [31:0]               frame_count,
    output logic                      err_tlast_early,
    output logic                      err_tlast_missing,
    input  logic                      err_clear
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = AXI_DATA_WIDTH + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [CNT_W-1:0]   count_reg;
    logic               run_reg;
    logic [31:0]        beat_count_reg;
    logic [31:0]        frame_count_reg;
    logic               push;
    logic               pop;
    logic [ENTRY_W-1:0] head;

    // run_reg keeps tready low during reset and releases it on the first edge afterwards.
    assign S_AXIS_tready = run_reg && (count_reg < DEPTH_C);
    assign push          = S_AXIS_tvalid && S_AXIS_tready;
    assign out_valid     = (count_reg != '0);
    assign pop           = out_valid && out_ready;

    assign head      = mem[rd_ptr_reg];
    assign out_pc    = head[XLEN-1:0];
    assign out_instr = head[AXI_DATA_WIDTH-1:XLEN];
    assign out_last  = head[AXI_DATA_WIDTH];

    assign beat_count  = beat_count_reg;
    assign frame_count = frame_count_reg;

    // Storage carries no reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= {S_AXIS_tlast, S_AXIS_tdata};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_reg    <= 1'b0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            run_reg <= 1'b1;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_count_reg  <= '0;
            frame_count_reg <= '0;
        end else if (push) begin
            if (beat_count_reg != 32'hFFFF_FFFF) begin
                beat_count_reg <= beat_count_reg + 32'd1;
            end
            if (S_AXIS_tlast) begin
                frame_count_reg <= frame_count_reg + 32'd1;
            end
        end
    end

`ifdef CMS_RX_TLAST_CHECK_EN
    logic [31:0] pos_reg;
    logic [31:0] pos_next;
    logic        interval_on;
    logic        early_set;
    logic        missing_set;
    logic        early_reg;
    logic        missing_reg;

    always_comb begin
        pos_next    = pos_reg + 32'd1;
        interval_on = (tlast_interval != 32'd0);
        early_set   = push && interval_on && S_AXIS_tlast && (pos_next < tlast_interval);
        missing_set = push && interval_on && !S_AXIS_tlast && (pos_next == tlast_interval);
    end

    // A set in the same cycle as err_clear takes priority so no event is lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos_reg     <= '0;
            early_reg   <= 1'b0;
            missing_reg <= 1'b0;
        end else begin
            if (push) begin
                if (S_AXIS_tlast || (pos_next == tlast_interval)) begin
                    pos_reg <= '0;
                end else begin
                    pos_reg <= pos_next;
                end
            end
            if (early_set) begin
                early_reg <= 1'b1;
            end else if (err_clear) begin
                early_reg <= 1'b0;
            end
            if (missing_set) begin
                missing_reg <= 1'b1;
            end else if (err_clear) begin
                missing_reg <= 1'b0;
            end
        end
    end

    assign err_tlast_early   = early_reg;
    assign err_tlast_missing = missing_reg;
`else
    logic unused_cfg;
    assign unused_cfg        = ^{err_clear, tlast_interval};
    assign err_tlast_early   = 1'b0;
    assign err_tlast_missing = 1'b0;
`endif

endmodule

// File: tb/tb_cms_trace_stream_receiver.sv
// Directed bench for cms_trace_stream_receiver; error expectations follow CMS_RX_TLAST_CHECK_EN.
module tb_cms_trace_stream_receiver;

`ifdef CMS_RX_TLAST_CHECK_EN
    localparam logic CHK = 1'b1;
`else
    localparam logic CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tvalid = 1'b0;
    logic        tready;
    logic [95:0] tdata = '0;
    logic        tlast = 1'b0;
    logic [31:0] tlast_interval = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_pc;
    logic [31:0] out_instr;
    logic        out_last;
    logic [31:0] beat_count;
    logic [31:0] frame_count;
    logic        err_early;
    logic        err_missing;
    logic        err_clear = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cms_trace_stream_receiver dut (
        .clk               (clk),
        .rst               (rst),
        .S_AXIS_tvalid     (tvalid),
        .S_AXIS_tready     (tready),
        .S_AXIS_tdata      (tdata),
        .S_AXIS_tlast      (tlast),
        .tlast_interval    (tlast_interval),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_pc            (out_pc),
        .out_instr         (out_instr),
        .out_last          (out_last),
        .beat_count        (beat_count),
        .frame_count       (frame_count),
        .err_tlast_early   (err_early),
        .err_tlast_missing (err_missing),
        .err_clear         (err_clear)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one beat and returns 1ns after the edge that accepted it.
    task automatic send(input logic [63:0] pc, input logic [31:0] ins, input logic last);
        int n = 0;
        tvalid = 1'b1;
        tdata  = {ins, pc};
        tlast  = last;
        while (!tready && n < 50) begin
            tick();
            n++;
        end
        check("tready_wait", 64'(n < 50), 64'd1);
        tick();
        tvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    initial begin
        // Reset state
        #1;
        check("rst_tready", 64'(tready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_beat_count", 64'(beat_count), 64'd0);
        check("rst_frame_count", 64'(frame_count), 64'd0);
        check("rst_err_early", 64'(err_early), 64'd0);
        check("rst_err_missing", 64'(err_missing), 64'd0);
        tick();
        rst = 1'b0;
        check("tready_low_before_edge", 64'(tready), 64'd0);
        tick();
        check("tready_after_release", 64'(tready), 64'd1);

        // Single beat, one-cycle latency
        out_ready = 1'b1;
        send(64'h8000_0008, 32'h0000_006f, 1'b0);
        check("single_valid", 64'(out_valid), 64'd1);
        check("single_pc", out_pc, 64'h8000_0008);
        check("single_instr", 64'(out_instr), 64'h6f);
        check("single_last", 64'(out_last), 64'd0);
        check("single_beat_count", 64'(beat_count), 64'd1);
        tick();
        check("single_popped", 64'(out_valid), 64'd0);

        // Fill with consumer stalled, then drain through a full+pop cycle
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(64'h100 + 64'(i), 32'hA0 + 32'(i), 1'b0);
        check("full_tready", 64'(tready), 64'd0);
        check("full_beat_count", 64'(beat_count), 64'd5);
        check("full_head_pc", out_pc, 64'h100);
        tvalid = 1'b1;
        tdata  = {32'hA4, 64'h104};
        tlast  = 1'b1;
        tick();
        check("held_beat_count", 64'(beat_count), 64'd5);
        check("stall_stable_pc", out_pc, 64'h100);
        check("stall_stable_instr", 64'(out_instr), 64'hA0);
        out_ready = 1'b1;
        tick();
        check("full_pop_no_push", 64'(beat_count), 64'd5);
        check("drain_pc1", out_pc, 64'h101);
        check("tready_after_pop", 64'(tready), 64'd1);
        tick();
        tvalid = 1'b0;
        tlast  = 1'b0;
        check("pushpop_beat_count", 64'(beat_count), 64'd6);
        check("pushpop_frame_count", 64'(frame_count), 64'd1);
        check("drain_pc2", out_pc, 64'h102);
        tick();
        check("drain_pc3", out_pc, 64'h103);
        tick();
        check("drain_pc4", out_pc, 64'h104);
        check("drain_instr4", 64'(out_instr), 64'hA4);
        check("drain_last4", 64'(out_last), 64'd1);
        tick();
        check("drain_empty", 64'(out_valid), 64'd0);

        // Correct 100-beat frame
        tlast_interval = 32'd100;
        for (int i = 1; i <= 100; i++) send(64'h1000 + 64'(i), 32'h13, i == 100);
        check("frame100_count", 64'(frame_count), 64'd2);
        check("frame100_beats", 64'(beat_count), 64'd106);
        check("frame100_early", 64'(err_early), 64'd0);
        check("frame100_missing", 64'(err_missing), 64'd0);

        // Early tlast on beat 50
        for (int i = 1; i <= 50; i++) send(64'h2000 + 64'(i), 32'h13, i == 50);
        check("early_set", 64'(err_early), 64'(CHK));
        check("early_no_missing", 64'(err_missing), 64'd0);
        check("early_frame_count", 64'(frame_count), 64'd3);
        tick();
        check("early_sticky", 64'(err_early), 64'(CHK));
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        check("early_cleared", 64'(err_early), 64'd0);

        // Missing tlast at interval 4, set-over-clear, then a clean frame
        tlast_interval = 32'd4;
        for (int i = 1; i <= 4; i++) send(64'h3000 + 64'(i), 32'h13, 1'b0);
        check("missing_set", 64'(err_missing), 64'(CHK));
        check("missing_no_early", 64'(err_early), 64'd0);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        check("missing_cleared", 64'(err_missing), 64'd0);
        err_clear = 1'b1;
        for (int i = 1; i <= 4; i++) send(64'h3100 + 64'(i), 32'h13, 1'b0);
        check("set_beats_clear", 64'(err_missing), 64'(CHK));
        tick();
        err_clear = 1'b0;
        check("missing_cleared2", 64'(err_missing), 64'd0);
        for (int i = 1; i <= 4; i++) send(64'h3200 + 64'(i), 32'h13, i == 4);
        check("clean4_missing", 64'(err_missing), 64'd0);
        check("clean4_early", 64'(err_early), 64'd0);
        check("clean4_frame_count", 64'(frame_count), 64'd4);
        check("clean4_beat_count", 64'(beat_count), 64'd168);

        // Asynchronous reset with buffered beats
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(64'h4000 + 64'(i), 32'h33, 1'b0);
        check("prereset_valid", 64'(out_valid), 64'd1);
        #1;
        rst = 1'b1;
        #1;
        check("async_out_valid", 64'(out_valid), 64'd0);
        check("async_beat_count", 64'(beat_count), 64'd0);
        check("async_frame_count", 64'(frame_count), 64'd0);
        check("async_tready", 64'(tready), 64'd0);
        tick();
        rst = 1'b0;
        tick();
        check("postreset_tready", 64'(tready), 64'd1);
        check("postreset_empty", 64'(out_valid), 64'd0);
        tick();
        check("postreset_no_stale", 64'(out_valid), 64'd0);
        out_ready = 1'b1;
        send(64'hDEAD_BEEF_0000_0010, 32'h0000_0013, 1'b0);
        check("postreset_pc", out_pc, 64'hDEAD_BEEF_0000_0010);
        check("postreset_instr", 64'(out_instr), 64'h13);
        check("postreset_beat_count", 64'(beat_count), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
